// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage types and constants: bus widths, the NOP encoding and the reset level.
package if_fetch_stage_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_bus_t;
  typedef logic [INST_W-1:0]      inst_bus_t;

  localparam inst_bus_t INST_NOP   = 32'h0000_0013;
  localparam inst_bus_t ZERO_WORD  = 32'h0000_0000;
  localparam logic      RST_ENABLE = 1'b1;

  // Redirect targets are forced onto a word boundary.
  function automatic inst_addr_bus_t word_align(input inst_addr_bus_t addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_pc_reg.sv
// Program counter register with its next-PC mux (redirect, hold on stall, or +4).
module pc_reg
  import if_fetch_stage_pkg::*;
#(
  parameter inst_addr_bus_t RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall_i,
  input  logic           jump_en_i,
  input  inst_addr_bus_t jump_addr_i,
  output inst_addr_bus_t pc_o
);

  inst_addr_bus_t pc_q;
  inst_addr_bus_t pc_d;

  // Redirect outranks stall; the +4 wraps modulo 2^32.
  always_comb begin
    pc_d = pc_q;
    if (jump_en_i) begin
      pc_d = word_align(jump_addr_i);
    end else if (!stall_i) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID register, misalign pulse and optional perf counters.
// Define IF_PERF_CNT_EN to build the saturating fetch/redirect counters.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter inst_addr_bus_t RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall_i,
  input  logic           flush_i,
  input  logic           jump_en_i,
  input  inst_addr_bus_t jump_addr_i,
  output inst_addr_bus_t inst_addr_o,
  input  inst_bus_t      inst_i,
  output inst_addr_bus_t ifid_pc_o,
  output inst_bus_t      ifid_inst_o,
  output logic           ifid_valid_o,
  output logic           misalign_o,
  output logic [31:0]    fetch_cnt_o,
  output logic [15:0]    redirect_cnt_o
);

  inst_addr_bus_t pc;
  inst_addr_bus_t ifid_pc_q,    ifid_pc_d;
  inst_bus_t      ifid_inst_q,  ifid_inst_d;
  logic           ifid_valid_q, ifid_valid_d;
  logic           misalign_q,   misalign_d;
  logic           load_valid;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .jump_en_i   (jump_en_i),
    .jump_addr_i (jump_addr_i),
    .pc_o        (pc)
  );

  assign inst_addr_o = pc;
  assign load_valid  = !jump_en_i && !stall_i && !flush_i;

  // Redirect and flush both bubble IF/ID; a plain stall holds it.
  always_comb begin
    ifid_pc_d    = ifid_pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_valid_d = ifid_valid_q;
    misalign_d   = jump_en_i && (jump_addr_i[1:0] != 2'b00);
    if (jump_en_i || flush_i) begin
      ifid_pc_d    = ZERO_WORD;
      ifid_inst_d  = INST_NOP;
      ifid_valid_d = 1'b0;
    end else if (!stall_i) begin
      ifid_pc_d    = pc;
      ifid_inst_d  = inst_i;
      ifid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      ifid_pc_q    <= ZERO_WORD;
      ifid_inst_q  <= INST_NOP;
      ifid_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_valid_q <= ifid_valid_d;
      misalign_q   <= misalign_d;
    end
  end

  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_inst_o  = ifid_inst_q;
  assign ifid_valid_o = ifid_valid_q;
  assign misalign_o   = misalign_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q,    fetch_cnt_d;
  logic [15:0] redirect_cnt_q, redirect_cnt_d;

  // Both counters stick at all-ones instead of wrapping.
  always_comb begin
    fetch_cnt_d    = fetch_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (load_valid && (fetch_cnt_q != '1)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (jump_en_i && (redirect_cnt_q != '1)) begin
      redirect_cnt_d = redirect_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      fetch_cnt_q    <= fetch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign fetch_cnt_o    = fetch_cnt_q;
  assign redirect_cnt_o = redirect_cnt_q;
`else
  logic unused_load_valid;
  assign unused_load_valid = load_valid;
  assign fetch_cnt_o       = 32'd0;
  assign redirect_cnt_o    = 16'd0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed vectors queue expected IF/ID contents, a monitor checks them.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i, jump_en_i;
  logic [31:0] jump_addr_i;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_i;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_inst_o;
  logic        ifid_valid_o;
  logic        misalign_o;
  logic [31:0] fetch_cnt_o;
  logic [15:0] redirect_cnt_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  logic loaded = 1'b0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_fetch_stage #(.RESET_PC(32'h0000_0004)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .jump_en_i      (jump_en_i),
    .jump_addr_i    (jump_addr_i),
    .inst_addr_o    (inst_addr_o),
    .inst_i         (inst_i),
    .ifid_pc_o      (ifid_pc_o),
    .ifid_inst_o    (ifid_inst_o),
    .ifid_valid_o   (ifid_valid_o),
    .misalign_o     (misalign_o),
    .fetch_cnt_o    (fetch_cnt_o),
    .redirect_cnt_o (redirect_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0000_0004: return 32'h0020_81B3;
      32'h0000_0008: return 32'h4052_0333;
      32'h0000_000C: return 32'h00C5_86B3;
      default:       return ~a;
    endcase
  endfunction

  assign inst_i = mem(inst_addr_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_addr"},  inst_addr_o, 32'h0000_0004);
    chk({tag, "_pc"},    ifid_pc_o, 32'h0);
    chk({tag, "_inst"},  ifid_inst_o, NOP);
    chk({tag, "_valid"}, {31'd0, ifid_valid_o}, 32'd0);
    chk({tag, "_mis"},   {31'd0, misalign_o}, 32'd0);
    chk({tag, "_fcnt"},  fetch_cnt_o, 32'd0);
    chk({tag, "_rcnt"},  {16'd0, redirect_cnt_o}, 32'd0);
  endtask

  // One clock: apply inputs, queue expected load if sequential, return at posedge+1.
  task automatic cyc(input logic st, input logic fl, input logic jp,
                     input logic [31:0] ja, input logic [31:0] fetch_pc);
    stall_i = st; flush_i = fl; jump_en_i = jp; jump_addr_i = ja;
    if (!st && !fl && !jp) exp_q.push_back('{pc: fetch_pc, inst: mem(fetch_pc)});
    @(posedge clk); #1;
  endtask

  always @(posedge clk) loaded <= !rst && !jump_en_i && !stall_i && !flush_i;

  always @(negedge clk) begin
    if (loaded) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL mon_unexpected: got pc %h with empty queue", ifid_pc_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_pc",    ifid_pc_o,   e.pc);
        chk("mon_inst",  ifid_inst_o, e.inst);
        chk("mon_valid", {31'd0, ifid_valid_o}, 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stall_i = 0; flush_i = 0; jump_en_i = 0; jump_addr_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("rst0");
    rst = 1'b0;

    // Reset release from RESET_PC=4, then sequential up to PC=0x10
    cyc(0, 0, 0, 0, 32'h4);
    cyc(0, 0, 0, 0, 32'h8);
    cyc(0, 0, 0, 0, 32'hC);
    chk("seq_addr", inst_addr_o, 32'h10);

    // Redirect to 0x40 from PC=0x10
    cyc(0, 0, 1, 32'h40, 0);
    chk("jmp_addr",  inst_addr_o, 32'h40);
    chk("jmp_valid", {31'd0, ifid_valid_o}, 32'd0);
    chk("jmp_inst",  ifid_inst_o, NOP);
    chk("jmp_mis",   {31'd0, misalign_o}, 32'd0);
    cyc(0, 0, 0, 0, 32'h40);
    chk("jmp_tgt_pc", ifid_pc_o, 32'h40);

    // Get to PC=0x20 with (0x1C) valid in IF/ID, then stall 3 cycles with flush on the 2nd
    cyc(0, 0, 1, 32'h1C, 0);
    cyc(0, 0, 0, 0, 32'h1C);
    cyc(1, 0, 0, 0, 0);
    chk("stall1_addr", inst_addr_o, 32'h20);
    chk("stall1_pc",   ifid_pc_o, 32'h1C);
    chk("stall1_inst", ifid_inst_o, mem(32'h1C));
    chk("stall1_vld",  {31'd0, ifid_valid_o}, 32'd1);
    cyc(1, 1, 0, 0, 0);
    chk("stall2_addr", inst_addr_o, 32'h20);
    chk("stall2_inst", ifid_inst_o, NOP);
    chk("stall2_vld",  {31'd0, ifid_valid_o}, 32'd0);
    cyc(1, 0, 0, 0, 0);
    chk("stall3_addr", inst_addr_o, 32'h20);
    chk("stall3_vld",  {31'd0, ifid_valid_o}, 32'd0);
    cyc(0, 0, 0, 0, 32'h20);
    chk("resume_addr", inst_addr_o, 32'h24);

    // Flush alone advances PC and bubbles
    cyc(0, 1, 0, 0, 0);
    chk("flush_addr", inst_addr_o, 32'h28);
    chk("flush_vld",  {31'd0, ifid_valid_o}, 32'd0);

    // Redirect with stall and flush, misaligned target
    cyc(1, 1, 1, 32'h106, 0);
    chk("mis_addr",  inst_addr_o, 32'h104);
    chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
    chk("mis_vld",   {31'd0, ifid_valid_o}, 32'd0);
    cyc(0, 0, 0, 0, 32'h104);
    chk("mis_clear", {31'd0, misalign_o}, 32'd0);

    // PC wrap
    cyc(0, 0, 1, 32'hFFFF_FFFC, 0);
    chk("wrap_pre", inst_addr_o, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 32'hFFFF_FFFC);
    chk("wrap_addr", inst_addr_o, 32'h0);

    // Asynchronous reset between edges
    cyc(0, 0, 0, 0, 32'h0);
    #6;
    rst = 1'b1;
    #1;
    chk_reset_state("arst");
    @(posedge clk); #1;
    rst = 1'b0;

    // Five valid fetches and one redirect for the counters
    cyc(0, 0, 0, 0, 32'h4);
    cyc(0, 0, 0, 0, 32'h8);
    cyc(0, 0, 0, 0, 32'hC);
    cyc(0, 0, 0, 0, 32'h10);
    cyc(0, 0, 0, 0, 32'h14);
    cyc(0, 0, 1, 32'h80, 0);
`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt_o, 32'd5);
    chk("redir_cnt", {16'd0, redirect_cnt_o}, 32'd1);
`else
    chk("fetch_cnt", fetch_cnt_o, 32'd0);
    chk("redir_cnt", {16'd0, redirect_cnt_o}, 32'd0);
`endif
    chk("cnt_addr", inst_addr_o, 32'h80);

    stall_i = 0; flush_i = 0; jump_en_i = 1; jump_addr_i = 32'h80;
    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage directly upstream of the instruction memory. Holds the program counter, drives the memory's byte read address, captures the returned 32-bit little-endian word into the IF/ID pipeline register, and handles stall, flush and branch/jump redirect requests from later stages. Instruction memory read is combinational, so one fetch completes per cycle.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall_i`  in  1  hazard-unit hold; freezes PC and IF/ID.
- `flush_i`  in  1  kill the instruction entering IF/ID this cycle.
- `jump_en_i`  in  1  redirect request from EX (taken branch, JAL, JALR).
- `jump_addr_i`  in  `InstAddrBus`  redirect target byte address.
- `inst_addr_o`  out  `InstAddrBus`  read address to instruction memory (= PC).
- `inst_i`  in  `InstBus`  word returned by instruction memory, same cycle.
- `ifid_pc_o`  out  `InstAddrBus`  PC of the instruction held in IF/ID.
- `ifid_inst_o`  out  `InstBus`  instruction held in IF/ID.
- `ifid_valid_o`  out  1  IF/ID holds a real instruction.
- `misalign_o`  out  1  one-cycle pulse: last redirect target had `jump_addr_i[1:0] != 0`.
- `fetch_cnt_o`  out  32  valid instructions delivered (see Configuration).
- `redirect_cnt_o`  out  16  redirects taken (see Configuration).

## Operation
- Reset values: PC = `RESET_PC`; `ifid_pc_o` = 0; `ifid_inst_o` = `INST_NOP` (32'h0000_0013); `ifid_valid_o` = 0; `misalign_o` = 0; counters = 0.
- `inst_addr_o` is driven directly from the PC register; no combinational path from any input to `inst_addr_o`.
- Per-edge priority, highest first: `rst`, `jump_en_i`, `stall_i`, sequential.
- Redirect (`jump_en_i`=1): PC <= `{jump_addr_i[31:2], 2'b00}`; IF/ID <= bubble (`INST_NOP`, valid 0, pc 0); `misalign_o` <= `|jump_addr_i[1:0]`. Overrides `stall_i` and `flush_i`.
- Stall (`stall_i`=1, no redirect): PC and IF/ID hold; `flush_i` still bubbles IF/ID while PC holds.
- Flush only (`flush_i`=1, no stall, no redirect): PC <= PC+4; IF/ID <= bubble.
- Sequential: PC <= PC+4; IF/ID <= {PC, `inst_i`, valid 1}.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0, no flag.
- `misalign_o` is 0 on every edge without a misaligned redirect.
- `inst_i` is not decoded or checked; undriven memory words pass through unchanged.

## Timing
- Fetch latency: PC = A at cycle N → `ifid_inst_o` = mem[A] and `ifid_pc_o` = A from cycle N+1.
- Redirect: `jump_en_i` at cycle N → `inst_addr_o` = target at N+1, bubble in IF/ID at N+1, target instruction valid in IF/ID at N+2. Redirect penalty is one bubble.
- Stall for k cycles: IF/ID and PC unchanged for k cycles; fetch resumes on the first edge with `stall_i`=0.
- First edge after `rst` deasserts captures mem[`RESET_PC`] with valid 1.
- `rst` asserted mid-operation clears all state immediately, without waiting for a clock edge.

## Configuration
- `IF_PERF_CNT_EN` defined: `fetch_cnt_o` increments on every edge that loads IF/ID with valid 1. `redirect_cnt_o` increments on every edge with `jump_en_i`=1. Both saturate at all-ones.
- `IF_PERF_CNT_EN` undefined: both outputs tied to 0 and no counter flops are instantiated.

## Structure
- The shared defines file carries `InstAddrBus`, `InstBus`, `INST_NOP` (32'h0000_0013), `ZeroWord` and `RstEnable`. The block adds none locally.
- One sub-module, `pc_reg`, holds the PC register and the next-PC mux (redirect/stall/+4) and takes `RESET_PC` as a parameter. `if_fetch_stage` holds the IF/ID register, `misalign_o` and the counters.

## Test plan
- Reset release, memory with words at byte addresses 4, 8 and 12: with `RESET_PC`=4, IF/ID shows (4, 0x002081B3) then (8, 0x40520333) on consecutive cycles, valid 1.
- `jump_en_i` with `jump_addr_i`=0x40 while PC=0x10: next cycle `inst_addr_o`=0x40 and `ifid_valid_o`=0; the following cycle `ifid_pc_o`=0x40.
- `stall_i` high for 3 cycles at PC=0x20: `inst_addr_o` stays 0x20 and IF/ID is frozen; with `flush_i` also high on the 2nd stall cycle, IF/ID becomes `INST_NOP` with valid 0.
- `jump_en_i`, `stall_i` and `flush_i` high together with `jump_addr_i`=0x106: PC=0x104 and `misalign_o` pulses for exactly one cycle.
- PC driven to 0xFFFF_FFFC: the next `inst_addr_o` is 0x0000_0000.
- `rst` asserted between clock edges mid-run: outputs reach reset values before the next edge. With `IF_PERF_CNT_EN` defined, 5 valid fetches and 1 redirect give `fetch_cnt_o`=5 and `redirect_cnt_o`=1.
